// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle RV32I control path:
//   - supported opcode constants
//   - controller state enumeration
//   - encodings of the result / ALU-A / ALU-B / alu_op / imm_src selects
//   - opcode helpers (legality check, immediate-format decode)
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    JAL,
    TRAP
  } state_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  function automatic logic op_is_legal(input logic [6:0] op);
    logic legal;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BRANCH, OP_JAL: legal = 1'b1;
      default:                                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Loads, I-ALU and anything unsupported fall back to the I format.
  function automatic imm_src_t imm_src_of(input logic [6:0] op);
    imm_src_t fmt;
    case (op)
      OP_STORE:  fmt = IMM_S;
      OP_BRANCH: fmt = IMM_B;
      OP_JAL:    fmt = IMM_J;
      default:   fmt = IMM_I;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive memory wait cycles of one access and flags the wait
// cycle in which the count reaches WAIT_MAX.
//   clk_i      in  clock
//   rst_n_i    in  asynchronous active-low reset
//   clr_i      in  clear the count (controller is entering a new state)
//   en_i       in  a wait cycle: memory state with ready low
//   expired_o  out this wait cycle is the WAIT_MAX-th one
// Only instantiated for WAIT_MAX > 0.
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] r_cnt;

  // Saturates at LAST: the controller leaves the memory state on expiry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Gated by en_i, so a ready in the limit cycle completes the access.
  assign expired_o = en_i && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Moore controller sequencing the shared multi-cycle RV32I datapath
// (one memory port, one ALU, IR/OldPC/ALUOut/Data registers).
// Parameters:
//   ILLEGAL_TRAP  1: unsupported opcode parks in TRAP; 0: retires as NOP
//   WAIT_MAX      max mem_ready_i wait cycles per access; 0 = no timeout
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   op_i, funct3_i        opcode / funct3 from IR (funct3_i[0]: beq/bne)
//   zero_i                ALU zero flag
//   mem_ready_i           memory completes the current access
//   mem_req_o/mem_write_o memory request / write strobe
//   adr_src_o             0 = PC, 1 = ALUOut
//   ir_write_o            IR and OldPC load enable
//   pc_write_o            PC load enable
//   reg_write_o           register-file write enable
//   result_src_o          00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a_o           00 PC, 01 OldPC, 10 rs1
//   alu_src_b_o           00 rs2, 01 ImmExt, 10 constant 4
//   alu_op_o              00 add, 01 sub, 10 funct-decoded
//   imm_src_o             I 00, S 01, B 10, J 11 (decoded from op_i)
//   retire_o              pulse on the last cycle of each instruction
//   illegal_o, timeout_o  unsupported opcode / memory wait timeout
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter bit          ILLEGAL_TRAP = 1'b1,
  parameter int unsigned WAIT_MAX     = 0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] imm_src_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic       timeout_o
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_illegal;
  logic   r_timeout;
  logic   w_legal;
  logic   w_in_mem;
  logic   w_wait;
  logic   w_state_change;
  logic   w_expired;
  logic   w_unused_funct3;

  assign w_legal         = op_is_legal(op_i);
  assign w_in_mem        = (r_state == FETCH) || (r_state == MEMREAD) ||
                           (r_state == MEMWRITE);
  assign w_wait          = w_in_mem && !mem_ready_i;
  assign w_state_change  = (w_state_nxt != r_state);
  assign w_unused_funct3 = ^funct3_i[2:1];

  // -------------------------------------------------------------------------
  // Memory wait timeout
  // -------------------------------------------------------------------------
  if (WAIT_MAX > 0) begin : g_timer
    mem_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
    ) u_timer (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clr_i     (w_state_change),
      .en_i      (w_wait),
      .expired_o (w_expired)
    );
  end else begin : g_no_timer
    logic w_unused_timer;
    assign w_unused_timer = w_wait ^ w_state_change;
    assign w_expired      = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH: begin
        if (mem_ready_i)    w_state_nxt = DECODE;
        else if (w_expired) w_state_nxt = TRAP;
      end
      DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: w_state_nxt = MEMADR;
          OP_RTYPE:          w_state_nxt = EXECR;
          OP_IALU:           w_state_nxt = EXECI;
          OP_BRANCH:         w_state_nxt = BRANCH;
          OP_JAL:            w_state_nxt = JAL;
          default:           w_state_nxt = ILLEGAL_TRAP ? TRAP : FETCH;
        endcase
      end
      MEMADR:   w_state_nxt = (op_i == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        if (mem_ready_i)    w_state_nxt = MEMWB;
        else if (w_expired) w_state_nxt = TRAP;
      end
      MEMWB:    w_state_nxt = FETCH;
      MEMWRITE: begin
        if (mem_ready_i)    w_state_nxt = FETCH;
        else if (w_expired) w_state_nxt = TRAP;
      end
      EXECR:    w_state_nxt = ALUWB;
      EXECI:    w_state_nxt = ALUWB;
      ALUWB:    w_state_nxt = FETCH;
      BRANCH:   w_state_nxt = FETCH;
      JAL:      w_state_nxt = ALUWB;
      TRAP:     w_state_nxt = TRAP;
      default:  w_state_nxt = FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and sticky fault flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == DECODE) && (w_state_nxt == TRAP)) r_illegal <= 1'b1;
      if (w_expired)                                    r_timeout <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode. Gated by rst_n_i so that every output is low during
  // reset while the state already sits in FETCH; the first request then
  // appears in the first cycle after release.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = RES_ALUOUT;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    alu_op_o     = ALUOP_ADD;
    imm_src_o    = IMM_I;
    retire_o     = 1'b0;
    illegal_o    = 1'b0;
    timeout_o    = 1'b0;
    if (rst_n_i) begin
      imm_src_o = imm_src_of(op_i);
      illegal_o = r_illegal;
      timeout_o = r_timeout;
      case (r_state)
        FETCH: begin
          mem_req_o    = 1'b1;
          alu_src_a_o  = SRCA_PC;
          alu_src_b_o  = SRCB_FOUR;
          alu_op_o     = ALUOP_ADD;
          result_src_o = RES_ALURESULT;
          ir_write_o   = mem_ready_i;
          pc_write_o   = mem_ready_i;
        end
        DECODE: begin
          alu_src_a_o = SRCA_OLDPC;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = ALUOP_ADD;
          illegal_o   = !w_legal;
          retire_o    = !w_legal && !ILLEGAL_TRAP;
        end
        MEMADR: begin
          alu_src_a_o = SRCA_RS1;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = ALUOP_ADD;
        end
        MEMREAD: begin
          mem_req_o    = 1'b1;
          adr_src_o    = 1'b1;
          result_src_o = RES_ALUOUT;
        end
        MEMWB: begin
          result_src_o = RES_DATA;
          reg_write_o  = 1'b1;
          retire_o     = 1'b1;
        end
        MEMWRITE: begin
          mem_req_o   = 1'b1;
          mem_write_o = 1'b1;
          adr_src_o   = 1'b1;
          retire_o    = mem_ready_i;
        end
        EXECR: begin
          alu_src_a_o = SRCA_RS1;
          alu_src_b_o = SRCB_RS2;
          alu_op_o    = ALUOP_FUNCT;
        end
        EXECI: begin
          alu_src_a_o = SRCA_RS1;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = ALUOP_FUNCT;
        end
        ALUWB: begin
          result_src_o = RES_ALUOUT;
          reg_write_o  = 1'b1;
          retire_o     = 1'b1;
        end
        BRANCH: begin
          alu_src_a_o  = SRCA_RS1;
          alu_src_b_o  = SRCB_RS2;
          alu_op_o     = ALUOP_SUB;
          result_src_o = RES_ALUOUT;
          pc_write_o   = zero_i ^ funct3_i[0];
          retire_o     = 1'b1;
        end
        JAL: begin
          alu_src_a_o  = SRCA_OLDPC;
          alu_src_b_o  = SRCB_FOUR;
          alu_op_o     = ALUOP_ADD;
          result_src_o = RES_ALUOUT;
          pc_write_o   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Two controllers side by side: index 0 traps on illegal opcodes and times
// out after 4 wait cycles, index 1 retires illegal opcodes as NOPs and never
// times out. One is exercised at a time while the other is held in reset.
// The driver walks each instruction through its phases, pushing the
// expected output vector for every cycle; a monitor pops and compares on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IA  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b1110011;
  localparam int LIMIT0 = 4;

  localparam int PH_RST = 0,  PH_F = 1,   PH_D = 2,    PH_ADR = 3, PH_RD = 4;
  localparam int PH_RWB = 5,  PH_WR = 6,  PH_EXR = 7,  PH_EXI = 8, PH_WB = 9;
  localparam int PH_BR  = 10, PH_JAL = 11, PH_TRAP = 12;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] alu;
    logic [1:0] imm;
    logic       retire;
    logic       illegal;
    logic       timeout;
  } obs_t;

  typedef struct {
    obs_t v;
    int   ph;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n [2];
  logic [6:0] op    [2];
  logic [2:0] f3    [2];
  logic       zero  [2];
  logic       rdy   [2];
  obs_t       obs   [2];

  logic [6:0] cur_op [2];
  logic [2:0] cur_f3 [2];
  bit         tr_ill [2];
  bit         tr_to  [2];
  exp_t       expq   [2][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       mreq, mwr, adr, irw, pcw, rw, ret, ill, tmo;
    logic [1:0] res, sa, sb, aop, imm;

    multicycle_ctrl_fsm #(
      .ILLEGAL_TRAP (g == 0),
      .WAIT_MAX     ((g == 0) ? LIMIT0 : 0)
    ) u_dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n[g]),
      .op_i         (op[g]),
      .funct3_i     (f3[g]),
      .zero_i       (zero[g]),
      .mem_ready_i  (rdy[g]),
      .mem_req_o    (mreq),
      .mem_write_o  (mwr),
      .adr_src_o    (adr),
      .ir_write_o   (irw),
      .pc_write_o   (pcw),
      .reg_write_o  (rw),
      .result_src_o (res),
      .alu_src_a_o  (sa),
      .alu_src_b_o  (sb),
      .alu_op_o     (aop),
      .imm_src_o    (imm),
      .retire_o     (ret),
      .illegal_o    (ill),
      .timeout_o    (tmo)
    );

    assign obs[g] = {mreq, mwr, adr, irw, pcw, rw, res, sa, sb, aop, imm,
                     ret, ill, tmo};
  end

  // ---------------------------------------------------------------------------
  // Reference: per-phase output table taken from the controller description
  // ---------------------------------------------------------------------------
  function automatic bit legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IA) ||
           (o == BR) || (o == JL);
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic obs_t model(input int ph, input logic r, input logic z,
                                 input logic [2:0] fn, input logic [6:0] o,
                                 input bit trap_mode, input bit t_ill,
                                 input bit t_to);
    obs_t e;
    e = '0;
    if (ph == PH_RST) return e;
    e.imm = imm_of(o);
    case (ph)
      PH_F:    begin e.mem_req = 1; e.b = 2'b10; e.res = 2'b10;
                     e.ir_write = r; e.pc_write = r; end
      PH_D:    begin e.a = 2'b01; e.b = 2'b01; e.illegal = !legal(o);
                     e.retire = !legal(o) && !trap_mode; end
      PH_ADR:  begin e.a = 2'b10; e.b = 2'b01; end
      PH_RD:   begin e.mem_req = 1; e.adr_src = 1; end
      PH_RWB:  begin e.res = 2'b01; e.reg_write = 1; e.retire = 1; end
      PH_WR:   begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1;
                     e.retire = r; end
      PH_EXR:  begin e.a = 2'b10; e.b = 2'b00; e.alu = 2'b10; end
      PH_EXI:  begin e.a = 2'b10; e.b = 2'b01; e.alu = 2'b10; end
      PH_WB:   begin e.reg_write = 1; e.retire = 1; end
      PH_BR:   begin e.a = 2'b10; e.alu = 2'b01; e.pc_write = z ^ fn[0];
                     e.retire = 1; end
      PH_JAL:  begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1; end
      PH_TRAP: begin e.illegal = t_ill; e.timeout = t_to; end
      default: ;
    endcase
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver helpers: one call = one clock cycle of controller d
  // ---------------------------------------------------------------------------
  task automatic cyc(input int d, input int ph, input logic r, input int zf);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n[d] = (ph != PH_RST);
    op[d]    = cur_op[d];
    f3[d]    = cur_f3[d];
    rdy[d]   = (ph == PH_F || ph == PH_RD || ph == PH_WR) ? r : 1'($urandom);
    zero[d]  = (zf < 0) ? 1'($urandom) : zf[0];
    e.v  = model(ph, rdy[d], zero[d], f3[d], op[d], d == 0, tr_ill[d], tr_to[d]);
    e.ph = ph;
    expq[d].push_back(e);
  endtask

  task automatic do_reset(input int d, input int n);
    tr_ill[d] = 0;
    tr_to[d]  = 0;
    repeat (n) cyc(d, PH_RST, 1'b0, -1);
  endtask

  task automatic access(input int d, input int ph, input int w, output bit to);
    int lim;
    lim = (d == 0) ? LIMIT0 : 0;
    to  = (lim != 0) && (w >= lim);
    for (int k = 0; k < (to ? lim : w); k++) cyc(d, ph, 1'b0, -1);
    if (!to) cyc(d, ph, 1'b1, -1);
  endtask

  task automatic trap_then_reset(input int d, input bit ill, input bit tmo,
                                 input int n);
    tr_ill[d] = ill;
    tr_to[d]  = tmo;
    repeat (n) cyc(d, PH_TRAP, 1'b0, -1);
    do_reset(d, 2);
  endtask

  task automatic do_instr(input int d, input logic [6:0] o, input logic [2:0] fn,
                          input int wf, input int wm, input int zbr);
    bit to;
    cur_op[d] = o;
    cur_f3[d] = fn;
    access(d, PH_F, wf, to);
    if (to) begin trap_then_reset(d, 1'b0, 1'b1, 5); return; end
    cyc(d, PH_D, 1'b0, -1);
    case (o)
      LW: begin
        cyc(d, PH_ADR, 1'b0, -1);
        access(d, PH_RD, wm, to);
        if (to) begin trap_then_reset(d, 1'b0, 1'b1, 5); return; end
        cyc(d, PH_RWB, 1'b0, -1);
      end
      SW: begin
        cyc(d, PH_ADR, 1'b0, -1);
        access(d, PH_WR, wm, to);
        if (to) begin trap_then_reset(d, 1'b0, 1'b1, 5); return; end
      end
      RT:      begin cyc(d, PH_EXR, 1'b0, -1); cyc(d, PH_WB, 1'b0, -1); end
      IA:      begin cyc(d, PH_EXI, 1'b0, -1); cyc(d, PH_WB, 1'b0, -1); end
      BR:      cyc(d, PH_BR, 1'b0, zbr);
      JL:      begin cyc(d, PH_JAL, 1'b0, -1); cyc(d, PH_WB, 1'b0, -1); end
      default: if (d == 0) trap_then_reset(d, 1'b1, 1'b0, 20);
    endcase
  endtask

  // Short reset pulse between clock edges in the middle of a store wait.
  // The store must vanish; the same cycle then behaves as a fresh FETCH.
  task automatic glitch(input int d);
    exp_t e;
    bit   to;
    cur_op[d] = SW;
    cur_f3[d] = 3'($urandom);
    access(d, PH_F, 0, to);
    cyc(d, PH_D, 1'b0, -1);
    cyc(d, PH_ADR, 1'b0, -1);
    cyc(d, PH_WR, 1'b0, -1);
    @(posedge clk);
    #1;
    cur_op[d] = RT;
    op[d]     = RT;
    f3[d]     = cur_f3[d];
    rdy[d]    = 1'b1;
    zero[d]   = 1'($urandom);
    rst_n[d]  = 1'b0;
    #1;
    checks++;
    if (obs[d] !== '0) begin
      errors++;
      $display("FAIL dut%0d reset_mid_store got %b want all zero", d, obs[d]);
    end
    #1;
    rst_n[d] = 1'b1;
    e.v  = model(PH_F, 1'b1, zero[d], f3[d], op[d], d == 0, 1'b0, 1'b0);
    e.ph = PH_F;
    expq[d].push_back(e);
    cyc(d, PH_D, 1'b0, -1);
    cyc(d, PH_EXR, 1'b0, -1);
    cyc(d, PH_WB, 1'b0, -1);
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] o;
    case ($urandom_range(0, 7))
      0: o = LW;
      1: o = SW;
      2: o = RT;
      3: o = IA;
      4: o = BR;
      5: o = JL;
      6: o = IA;
      default: begin
        o = 7'($urandom);
        if (legal(o)) o = o ^ 7'b0000100;
      end
    endcase
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        if (expq[d].size() > 0) begin
          e = expq[d].pop_front();
          checks++;
          if (obs[d] !== e.v) begin
            errors++;
            $display("FAIL dut%0d phase%0d outputs got %b want %b",
                     d, e.ph, obs[d], e.v);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; op[d] = '0; f3[d] = '0; zero[d] = 1'b0; rdy[d] = 1'b0;
      cur_op[d] = RT; cur_f3[d] = '0; tr_ill[d] = 0; tr_to[d] = 0;
    end

    for (int d = 0; d < 2; d++) begin
      do_reset(d, 3);
      do_instr(d, RT, 3'($urandom), 0, 0, -1);
      do_instr(d, LW, 3'($urandom), 0, 3, -1);
      do_instr(d, BR, 3'b000, 0, 0, 1);
      do_instr(d, BR, 3'b001, 0, 0, 1);
      do_instr(d, SW, 3'($urandom), 1, 2, -1);
      do_instr(d, JL, 3'($urandom), 0, 0, -1);
      do_instr(d, IA, 3'($urandom), 2, 0, -1);
      do_instr(d, RT, 3'($urandom), LIMIT0 - 1, 0, -1);
      do_instr(d, RT, 3'($urandom), LIMIT0, 0, -1);
      do_instr(d, SW, 3'($urandom), 0, LIMIT0, -1);
      do_instr(d, ILL, 3'($urandom), 0, 0, -1);
      glitch(d);
      for (int n = 0; n < 40; n++) begin
        int wf, wm;
        wf = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
        wm = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
        do_instr(d, pick_op(), 3'($urandom), wf, wm, -1);
      end
      do_reset(d, 2);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog simulation did not complete got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Moore state machine that sequences the shared multi-cycle RV32I datapath: one memory port, one ALU and the instruction/data registers are reused across several cycles per instruction. The FSM owns the PC, IR, register-file and memory write strobes, the mux selects and the ALU-op class. An external ALU decoder turns alu_op_o into the ALU function. Memory accesses use a req/ready handshake with optional timeout.

Parameters:
ILLEGAL_TRAP, 1, 1: an unsupported opcode parks the FSM in TRAP; 0: it retires as a NOP.
WAIT_MAX, 0, maximum mem_ready_i wait cycles per access; 0 disables the timeout.

Ports:
clk_i  in  1  clock; single clock domain
rst_n_i  in  1  asynchronous active-low reset
op_i  in  7  opcode from the instruction register; valid from DECODE onward
funct3_i  in  3  IR funct3; bit 0 selects beq (0) or bne (1)
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory completes the current access this cycle
mem_req_o  out  1  memory access request
mem_write_o  out  1  memory write strobe, qualified by mem_req_o
adr_src_o  out  1  address select: 0 = PC, 1 = ALUOut
ir_write_o  out  1  IR and OldPC load enable
pc_write_o  out  1  PC load enable
reg_write_o  out  1  register-file write enable
result_src_o  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a_o  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
alu_src_b_o  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
alu_op_o  out  2  ALU-op class: 00 = add, 01 = sub, 10 = funct-decoded
imm_src_o  out  2  immediate format decoded from op_i: I = 00, S = 01, B = 10, J = 11
retire_o  out  1  one-cycle pulse on the last cycle of each instruction
illegal_o  out  1  unsupported opcode was decoded
timeout_o  out  1  a memory wait exceeded WAIT_MAX

Behaviour:
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, branch 1100011 (beq/bne), jal 1101111. Any other opcode is illegal.
- Reset: asynchronous, state goes to FETCH, wait counter clears, illegal_o and timeout_o clear. While rst_n_i is low every output is 0. The first request is issued in the first cycle after release.
- All outputs are decoded from the state only, except the ready-qualified strobes and the branch pc_write_o. Every select output not listed for a state is 00.
- FETCH: mem_req_o = 1, adr_src_o = 0, A = PC, B = 4, alu_op_o = 00, result_src_o = 10. ir_write_o and pc_write_o are asserted only in the cycle mem_ready_i = 1; FSM then moves to DECODE, otherwise it holds.
- DECODE: A = OldPC, B = Imm, alu_op_o = 00 (branch target into ALUOut). Next state by opcode: lw or sw -> MEMADR; R-type -> EXECR; I-ALU -> EXECI; branch -> BRANCH; jal -> JAL; illegal -> TRAP if ILLEGAL_TRAP = 1, else FETCH with retire_o = 1.
- MEMADR: A = rs1, B = Imm, alu_op_o = 00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: mem_req_o = 1, adr_src_o = 1, result_src_o = 00. On ready -> MEMWB.
- MEMWB: result_src_o = 01, reg_write_o = 1, retire_o = 1 -> FETCH.
- MEMWRITE: mem_req_o = 1, mem_write_o = 1, adr_src_o = 1. On ready, retire_o = 1 -> FETCH.
- EXECR: A = rs1, B = rs2, alu_op_o = 10 -> ALUWB. EXECI: A = rs1, B = Imm, alu_op_o = 10 -> ALUWB.
- ALUWB: result_src_o = 00, reg_write_o = 1, retire_o = 1 -> FETCH.
- BRANCH: A = rs1, B = rs2, alu_op_o = 01, result_src_o = 00. pc_write_o = zero_i XOR funct3_i[0]. retire_o = 1 -> FETCH.
- JAL: A = OldPC, B = 4, alu_op_o = 00, result_src_o = 00, pc_write_o = 1 -> ALUWB (rd receives PC+4).
- TRAP: every strobe is 0; illegal_o or timeout_o is held at 1; exit only by reset. With ILLEGAL_TRAP = 0, illegal_o is a one-cycle pulse in DECODE instead.
- Latency with zero memory wait: lw 5 cycles, sw 4, R/I 4, branch 3, jal 4. Each memory wait cycle adds 1.
- Wait counter: cleared on every state entry. It increments each cycle of a memory state with mem_ready_i = 0.
  - If WAIT_MAX > 0 and the counter reaches WAIT_MAX while ready is still low: go to TRAP and set timeout_o.
  - Ready in the same cycle the limit is reached wins: no timeout.
- mem_ready_i is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset mid-access drops mem_req_o immediately. The aborted instruction produces no retire_o, pc_write_o or reg_write_o.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants;
  - the state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP);
  - the encodings of the result, A-source, B-source, alu_op and imm_src selects.
- One sub-module: mem_wait_timer (counter with clear/enable, parameter WAIT_MAX, expired output). It is tied off when WAIT_MAX = 0.

Test Plan:
- Release reset with mem_ready_i = 1, op_i = 0110011 -> states FETCH, DECODE, EXECR, ALUWB; retire_o in cycle 4; reg_write_o only in ALUWB; pc_write_o only in FETCH.
- lw with mem_ready_i low for 3 cycles in MEMREAD (WAIT_MAX = 0) -> mem_req_o = 1 and adr_src_o = 1 throughout; MEMWB follows the ready cycle; 8 cycles total.
- Branch with funct3 = 000, zero_i = 1 -> pc_write_o = 1 in BRANCH. Same with funct3 = 001 -> pc_write_o = 0. Each takes 3 cycles.
- op_i = 1110011: ILLEGAL_TRAP = 1 -> TRAP, illegal_o held, mem_req_o stays 0 for 20 cycles. ILLEGAL_TRAP = 0 -> back to FETCH with a one-cycle illegal_o pulse.
- WAIT_MAX = 4, ready held low in FETCH -> TRAP after 4 wait cycles with timeout_o = 1. Ready on wait cycle 4 -> normal DECODE.
- Assert rst_n_i mid-MEMWRITE -> mem_req_o and mem_write_o drop asynchronously; no retire_o; FETCH after release.
